// File: rtl/sevenseg_capture.sv
// ---------------------------------------------------------------------------
// sevenseg_capture
//
// Watches a multiplexed 4-digit seven-segment display bus and reconstructs
// the displayed frame. Each (anot, seg) pair must hold still for STABLE_CYC
// clock cycles before it is treated as a real digit. Digits are collected in
// slot order (slot0..slot3). A complete frame is offered on a valid/ready
// handshake.
//
// Optional feature macro: SEVENSEG_SCORE_DECODE_EN
//   When defined, a frame shaped "B x C y" (x, y <= 4) is flagged through
//   score_mode, with x on bulls and y on cows. When undefined, those outputs
//   are tied to zero.
//
// Ports
//   clk          : rising-edge clock
//   reset        : asynchronous reset, active low (0 = in reset)
//   anot[3:0]    : anode bus, active-low one-hot (0111 = slot0 ... 1110 = slot3)
//   seg[6:0]     : cathode bus, active low, bit6 = A ... bit0 = G
//   frame_data   : captured frame, slot0 in [15:12] ... slot3 in [3:0]
//   frame_valid  : frame_data holds an unaccepted frame
//   frame_ready  : consumer accepts the frame when frame_valid is also 1
//   seg_err      : sticky, an undecodable stable segment pattern was seen
//   overrun      : sticky, a frame completed while the previous one was pending
//   err_clr      : synchronous clear of seg_err and overrun (a new set wins)
//   score_mode   : frame has the "B x C y" score layout
//   bulls, cows  : x and y of a score frame, otherwise 0
// ---------------------------------------------------------------------------
module sevenseg_capture #(
    parameter int STABLE_CYC = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  anot,
    input  logic [6:0]  seg,
    output logic [15:0] frame_data,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        seg_err,
    output logic        overrun,
    input  logic        err_clr,
    output logic        score_mode,
    output logic [2:0]  bulls,
    output logic [2:0]  cows
);

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] codes_q, codes_d;
    logic [10:0] pair_q;
    logic [7:0]  cnt_q;

    logic [10:0] pair_in;
    logic        strobe;
    logic        slot_ok;
    logic [1:0]  slot;
    logic        code_ok;
    logic [3:0]  code;
    logic        err_evt;
    logic        load_frame;
    logic        overrun_evt;

    assign pair_in = {anot, seg};

    // The strobe fires on the single cycle where the counter steps onto
    // STABLE_CYC; once saturated it cannot fire again until the pair changes.
    assign strobe = (pair_in == pair_q) && (cnt_q == 8'(STABLE_CYC - 1));

    // Stability tracker: remembers the last pair and how long it has held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pair_q <= 11'h7FF;
            cnt_q  <= 8'd0;
        end else if (pair_in != pair_q) begin
            pair_q <= pair_in;
            cnt_q  <= 8'd1;
        end else if (cnt_q != 8'(STABLE_CYC)) begin
            cnt_q  <= cnt_q + 8'd1;
        end
    end

    // Anode decode: only a single low bit names a slot.
    always_comb begin
        slot_ok = 1'b1;
        slot    = 2'd0;
        case (anot)
            4'b0111: slot = 2'd0;
            4'b1011: slot = 2'd1;
            4'b1101: slot = 2'd2;
            4'b1110: slot = 2'd3;
            default: slot_ok = 1'b0;
        endcase
    end

    // Segment decode to a hex code; anything not in the table is an error.
    always_comb begin
        code_ok = 1'b1;
        code    = 4'h0;
        case (seg)
            7'b0000001: code = 4'h0;
            7'b1001111: code = 4'h1;
            7'b0010010: code = 4'h2;
            7'b0000110: code = 4'h3;
            7'b1001100: code = 4'h4;
            7'b0100100: code = 4'h5;
            7'b0100000: code = 4'h6;
            7'b0001111: code = 4'h7;
            7'b0000000: code = 4'h8;
            7'b0000100: code = 4'h9;
            7'b0001000: code = 4'hA;
            7'b1100000: code = 4'hB;
            7'b0110001: code = 4'hC;
            7'b1000010: code = 4'hD;
            7'b0110000: code = 4'hE;
            7'b0111000: code = 4'hF;
            default:    code_ok = 1'b0;
        endcase
    end

    // Frame assembly state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SYNC;
            idx_q   <= 2'd0;
            codes_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            codes_q <= codes_d;
        end
    end

    // Next-state logic. Strobes on a non-slot anode pattern are dropped
    // without touching state. A wrong-order slot0 restarts the frame
    // immediately so a display that skipped a digit resynchronises fast.
    // Slot fields are addressed with {~slot, 2'b00}, which is (3 - slot) * 4.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        codes_d    = codes_q;
        err_evt    = 1'b0;
        load_frame = (state_q == FULL);

        if (state_q == FULL) begin
            state_d = SYNC;
            idx_d   = 2'd0;
        end else if (strobe && slot_ok) begin
            if (!code_ok) begin
                err_evt = 1'b1;
                state_d = SYNC;
                idx_d   = 2'd0;
            end else if (state_q == SYNC) begin
                if (slot == 2'd0) begin
                    codes_d[15:12] = code;
                    idx_d          = 2'd1;
                    state_d        = COLLECT;
                end
            end else if (slot == idx_q) begin
                codes_d[{~slot, 2'b00} +: 4] = code;
                idx_d                        = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = FULL;
                end
            end else if (slot == 2'd0) begin
                codes_d[15:12] = code;
                idx_d          = 2'd1;
            end else begin
                state_d = SYNC;
                idx_d   = 2'd0;
            end
        end
    end

    assign overrun_evt = load_frame && frame_valid && !frame_ready;

    // Output frame register with valid/ready handshake. A fresh frame always
    // overwrites, even one that has not been accepted yet.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_data  <= 16'h0000;
            frame_valid <= 1'b0;
        end else if (load_frame) begin
            frame_data  <= codes_q;
            frame_valid <= 1'b1;
        end else if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
        end
    end

    // Sticky error flags; a set in the same cycle as err_clr takes priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_err <= 1'b0;
            overrun <= 1'b0;
        end else begin
            seg_err <= err_evt     | (seg_err & ~err_clr);
            overrun <= overrun_evt | (overrun & ~err_clr);
        end
    end

`ifdef SEVENSEG_SCORE_DECODE_EN
    logic is_score;

    assign is_score = (codes_q[15:12] == 4'hB) && (codes_q[7:4] == 4'hC) &&
                      (codes_q[11:8] <= 4'd4) && (codes_q[3:0] <= 4'd4);

    // Score fields are updated together with frame_data so they always
    // describe the frame currently on offer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            score_mode <= 1'b0;
            bulls      <= 3'd0;
            cows       <= 3'd0;
        end else if (load_frame) begin
            score_mode <= is_score;
            bulls      <= is_score ? codes_q[10:8] : 3'd0;
            cows       <= is_score ? codes_q[2:0]  : 3'd0;
        end
    end
`else
    assign score_mode = 1'b0;
    assign bulls      = 3'd0;
    assign cows       = 3'd0;
`endif

endmodule

// File: tb/tb_sevenseg_capture.sv
// ---------------------------------------------------------------------------
// tb_sevenseg_capture
//
// Self-checking bench for sevenseg_capture (STABLE_CYC = 4). Expected frames
// are queued as scans are driven and compared whenever the design completes
// a valid/ready handshake. Status flags are checked directly at the points
// where their value is known.
// ---------------------------------------------------------------------------
module tb_sevenseg_capture;

    logic        clk;
    logic        reset;
    logic [3:0]  anot;
    logic [6:0]  seg;
    logic [15:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic        seg_err;
    logic        overrun;
    logic        err_clr;
    logic        score_mode;
    logic [2:0]  bulls;
    logic [2:0]  cows;

    int          tests_run;
    int          tests_failed;
    int          hs_count;
    logic [15:0] exp_q[$];
    logic [6:0]  seg_tab[16];
    logic [3:0]  anode_tab[4];

    sevenseg_capture #(.STABLE_CYC(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .anot        (anot),
        .seg         (seg),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .seg_err     (seg_err),
        .overrun     (overrun),
        .err_clr     (err_clr),
        .score_mode  (score_mode),
        .bulls       (bulls),
        .cows        (cows)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Hold one (anot, seg) pair for the given number of rising edges.
    task automatic hold_pair(input logic [3:0] a, input logic [6:0] s, input int dwell);
        anot = a;
        seg  = s;
        repeat (dwell) @(negedge clk);
    endtask

    // Scan a 4-digit frame in slot order, then go idle for a few cycles.
    task automatic applyStimulus(input logic [15:0] digits, input int dwell);
        for (int i = 0; i < 4; i++) begin
            hold_pair(anode_tab[i], seg_tab[digits[(3 - i) * 4 +: 4]], dwell);
        end
        hold_pair(4'b1111, 7'b1111111, 4);
    endtask

    // Bounded wait until the scoreboard has drained.
    task automatic wait_drain(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        checkOutput(tag, exp_q.size(), 0);
    endtask

    // Scoreboard consumer: every accepted frame must match the oldest entry.
    always @(negedge clk) begin
        if (reset && frame_valid && frame_ready) begin
            hs_count++;
            if (exp_q.size() == 0)
                checkOutput("unexpected_frame", exp_q.size(), 1);
            else
                checkOutput("frame", frame_data, exp_q.pop_front());
        end
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        hs_count     = 0;
        seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        anode_tab = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

        reset       = 1'b0;
        anot        = 4'b1111;
        seg         = 7'b1111111;
        frame_ready = 1'b1;
        err_clr     = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("rst_frame_data", frame_data, 16'h0000);
        checkOutput("rst_frame_valid", frame_valid, 0);
        checkOutput("rst_seg_err", seg_err, 0);
        checkOutput("rst_overrun", overrun, 0);
        checkOutput("rst_score_mode", score_mode, 0);
        checkOutput("rst_bulls", bulls, 0);
        checkOutput("rst_cows", cows, 0);

        reset = 1'b1;
        @(negedge clk);

        // Basic scan, one frame, one handshake.
        exp_q.push_back(16'h1234);
        applyStimulus(16'h1234, 6);
        wait_drain("drain_1234");
        checkOutput("pulses_1234", hs_count, 1);
        checkOutput("valid_after_1234", frame_valid, 0);
        checkOutput("score_1234", score_mode, 0);

        // Score layout frame.
        exp_q.push_back(16'hB2C1);
        applyStimulus(16'hB2C1, 6);
        wait_drain("drain_b2c1");
`ifdef SEVENSEG_SCORE_DECODE_EN
        checkOutput("score_mode_b2c1", score_mode, 1);
        checkOutput("bulls_b2c1", bulls, 2);
        checkOutput("cows_b2c1", cows, 1);
`else
        checkOutput("score_mode_b2c1", score_mode, 0);
        checkOutput("bulls_b2c1", bulls, 0);
        checkOutput("cows_b2c1", cows, 0);
`endif

        // Dwell one cycle too short: nothing may be latched.
        applyStimulus(16'h4321, 3);
        repeat (4) @(negedge clk);
        checkOutput("short_dwell_pulses", hs_count, 2);
        checkOutput("short_dwell_valid", frame_valid, 0);

        // Blank segments on slot2 abort the partial frame.
        hold_pair(anode_tab[0], seg_tab[7], 6);
        hold_pair(anode_tab[1], seg_tab[7], 6);
        hold_pair(anode_tab[2], 7'b1111111, 6);
        hold_pair(anode_tab[3], seg_tab[7], 6);
        hold_pair(4'b1111, 7'b1111111, 4);
        checkOutput("seg_err_set", seg_err, 1);
        checkOutput("seg_err_no_frame", hs_count, 2);
        exp_q.push_back(16'h0001);
        applyStimulus(16'h0001, 6);
        wait_drain("drain_0001");
        checkOutput("seg_err_sticky", seg_err, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checkOutput("seg_err_cleared", seg_err, 0);

        // Two frames with no consumer: overrun, second frame retained.
        frame_ready = 1'b0;
        applyStimulus(16'h1234, 6);
        checkOutput("pending_valid", frame_valid, 1);
        checkOutput("pending_data", frame_data, 16'h1234);
        checkOutput("no_overrun_yet", overrun, 0);
        applyStimulus(16'h5678, 6);
        checkOutput("overrun_set", overrun, 1);
        checkOutput("overrun_data", frame_data, 16'h5678);
        checkOutput("overrun_valid", frame_valid, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checkOutput("overrun_cleared", overrun, 0);
        exp_q.push_back(16'h5678);
        frame_ready = 1'b1;
        wait_drain("drain_overrun");
        @(negedge clk);
        checkOutput("valid_after_accept", frame_valid, 0);

        // Reset while a frame is pending and another is half-collected.
        frame_ready = 1'b0;
        applyStimulus(16'h9ABC, 6);
        checkOutput("pre_reset_valid", frame_valid, 1);
        hold_pair(anode_tab[0], seg_tab[5], 6);
        hold_pair(anode_tab[1], seg_tab[6], 6);
        hold_pair(anode_tab[2], seg_tab[7], 6);
        reset = 1'b0;
        #1;
        checkOutput("midrst_valid", frame_valid, 0);
        checkOutput("midrst_data", frame_data, 16'h0000);
        checkOutput("midrst_score", score_mode, 0);
        hold_pair(4'b1111, 7'b1111111, 3);
        reset       = 1'b1;
        frame_ready = 1'b1;
        @(negedge clk);
        exp_q.push_back(16'h5678);
        applyStimulus(16'h5678, 6);
        wait_drain("drain_after_reset");
        checkOutput("final_pulses", hs_count, 5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sevenseg_capture.md
SEVENSEG_CAPTURE -- requirements
Module: sevenseg_capture

Interface
REQ-001 Parameter STABLE_CYC, default 4, is the number of consecutive clk cycles an (anot, seg) pair must hold unchanged before the digit is latched; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserted = 0.
REQ-004 anot  input  4  multiplexed display anode bus, active-low one-hot: 0111=slot0 (leftmost), 1011=slot1, 1101=slot2, 1110=slot3.
REQ-005 seg  input  7  cathode bus, active-low, bit6=A ... bit0=G.
REQ-006 frame_data  output  16  captured frame, slot0 in [15:12] through slot3 in [3:0], one 4-bit code per slot.
REQ-007 frame_valid  output  1  captured frame available; held until accepted.
REQ-008 frame_ready  input  1  consumer accepts frame_data when frame_valid=1 and frame_ready=1 in the same cycle.
REQ-009 seg_err  output  1  sticky flag: an unrecognised stable segment pattern was seen.
REQ-010 overrun  output  1  sticky flag: a frame completed while the previous one was still pending.
REQ-011 err_clr  input  1  synchronous clear of seg_err and overrun.
REQ-012 score_mode  output  1  frame matches "b x C y" layout (only with SEVENSEG_SCORE_DECODE_EN).
REQ-013 bulls, cows  output  3 each  x and y of a score frame, values 0..4; 0 otherwise.

Function
REQ-014 Decode table, pattern -> code: 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 0001000->A, 1100000->B, 0110001->C, 1000010->D, 0110000->E, 0111000->F.
REQ-015 Stability counter: resets to 1 on any change of {anot, seg}; saturates at STABLE_CYC; reaching STABLE_CYC fires one latch strobe per dwell, never re-firing until the pair changes.
REQ-016 Latch strobe with anot not one-hot-low (including 1111 or 0000): ignored; the FSM state is unchanged.
REQ-017 Latch strobe with an undecodable seg: seg_err set; the FSM goes to SYNC and discards the partial frame.
REQ-018 FSM states are SYNC, COLLECT and FULL; the slot index is 2 bits.
REQ-019 SYNC: a valid slot0 strobe stores the code, sets the index to 1 and enters COLLECT; strobes for other slots are ignored.
REQ-020 COLLECT: a valid strobe for the slot equal to the index stores the code and increments the index; storing slot3 enters FULL.
REQ-021 COLLECT: a strobe for a slot not equal to the index discards the partial frame; it restarts at slot1 if the strobe was slot0, otherwise it enters SYNC.
REQ-022 FULL: the 4 codes are copied to frame_data and frame_valid is set on the next cycle (latency 1 clk after the slot3 strobe); the FSM returns to SYNC in the same cycle.
REQ-023 frame_valid and frame_data remain stable until handshake; frame_valid clears the cycle after handshake.
REQ-024 A new FULL while frame_valid=1 and no handshake in that cycle: overrun set, frame_data overwritten, frame_valid stays 1.
REQ-025 A new FULL in the same cycle as handshake: the new frame loads, frame_valid stays 1, overrun unchanged.
REQ-026 err_clr coinciding with a new error event: the set wins.

Reset
REQ-027 While reset=0: the FSM is SYNC, the index is 0, the stability counter is 0, the stored pair is 1111/1111111, frame_data=0, frame_valid=0, seg_err=0, overrun=0, score_mode=0, bulls=0, cows=0.
REQ-028 Reset asserted mid-frame or while frame_valid=1 discards all captured data with no handshake; capture resumes at the first full dwell after release.

Configuration
REQ-029 SEVENSEG_SCORE_DECODE_EN defined: score_mode=1 when frame_data[15:12]=B, [7:4]=C, and [11:8] and [3:0] are each <=4. In that case bulls=[11:8] and cows=[3:0], registered with frame_valid.
REQ-030 SEVENSEG_SCORE_DECODE_EN undefined: score_mode, bulls and cows are tied to 0 and the decode logic is absent.

Verification
REQ-031 Scan 1,2,3,4 in slot order, 6 cycles per dwell, frame_ready=1 -> frame_data=16'h1234, one frame_valid pulse.
REQ-032 Scan B,2,C,1 with the macro defined -> score_mode=1, bulls=2, cows=1; with the macro undefined -> score_mode=0, bulls=0, cows=0.
REQ-033 Dwell of 3 cycles with STABLE_CYC=4 -> no strobe, frame_valid stays 0.
REQ-034 seg=1111111 stable on slot2 -> seg_err=1, the partial frame is dropped, and the next clean 0,0,0,1 scan gives frame_data=16'h0001.
REQ-035 Two complete frames with frame_ready=0 -> overrun=1 and frame_data holds the second frame; err_clr=1 -> overrun=0.
REQ-036 reset=0 after slot2 is latched -> all outputs return to their reset values, and a following 5,6,7,8 scan gives frame_data=16'h5678.
